// File: rtl/conv_tile_drain_if.sv
// Tile capture and output stream bundle of the convolution tile drain stage.
// slave = the drain itself, master = the conv engine / write-back side driving it.
interface conv_tile_drain_if #(
    parameter int ACC_W   = 16,
    parameter int BIAS_W  = 16,
    parameter int SHIFT_W = 4,
    parameter int OUT_W   = 8
);
    logic                              tile_valid;
    logic                              tile_ready;
    logic [3:0][3:0][ACC_W-1:0]        c_in;
    logic signed [BIAS_W-1:0]          bias;
    logic [SHIFT_W-1:0]                shift;
    logic                              relu_en;
    logic                              out_valid;
    logic                              out_ready;
    logic signed [OUT_W-1:0]           out_data;
    logic [1:0]                        out_row;
    logic [1:0]                        out_col;
    logic                              out_last;
    logic                              tile_done;

    modport slave (
        input  tile_valid, c_in, bias, shift, relu_en, out_ready,
        output tile_ready, out_valid, out_data, out_row, out_col, out_last, tile_done
    );

    modport master (
        output tile_valid, c_in, bias, shift, relu_en, out_ready,
        input  tile_ready, out_valid, out_data, out_row, out_col, out_last, tile_done
    );
endinterface

// File: rtl/conv_tile_drain.sv
// Captures a 4x4 accumulator tile, requantises it (bias, round/shift, ReLU, int8 saturation)
// and streams it row-major. Define CONV_DRAIN_MAXPOOL_EN to emit a 2x2 max-pooled tile instead.
module conv_tile_drain #(
    parameter int ACC_W   = 16,
    parameter int BIAS_W  = 16,
    parameter int SHIFT_W = 4,
    parameter int OUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_tile_drain_if.slave  bus
);
    localparam int S_W = ACC_W + 2;
`ifdef CONV_DRAIN_MAXPOOL_EN
    localparam int IDX_W = 2;
`else
    localparam int IDX_W = 4;
`endif
    localparam logic [IDX_W-1:0]      LAST_IDX = '1;
    localparam logic signed [S_W-1:0] SAT_HI   = (S_W'(1) <<< (OUT_W - 1)) - S_W'(1);
    localparam logic signed [S_W-1:0] SAT_LO   = ~SAT_HI;

    typedef enum logic {IDLE, EMIT} state_t;
    typedef logic [3:0][3:0][ACC_W-1:0] tile_t;

    state_t                   state_reg, state_next;
    tile_t                    tile_reg, src_tile;
    logic signed [BIAS_W-1:0] bias_reg, src_bias;
    logic [SHIFT_W-1:0]       shift_reg, src_shift;
    logic                     relu_reg, src_relu;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic                     out_valid_reg, last_reg, done_reg;
    logic signed [OUT_W-1:0]  out_data_reg, elem_q;
    logic [1:0]               row_reg, col_reg, row_next, col_next;
    logic                     capture, beat_hs, last_hs;

    function automatic logic signed [OUT_W-1:0] requant(
        input logic [ACC_W-1:0]        c,
        input logic signed [BIAS_W-1:0] b,
        input logic [SHIFT_W-1:0]      sh,
        input logic                    relu
    );
        logic signed [S_W-1:0] s;
        logic signed [S_W-1:0] rnd;
        s   = $signed({2'b00, c}) + $signed({{(S_W-BIAS_W){b[BIAS_W-1]}}, b});
        rnd = '0;
        if (sh != '0)
            rnd = S_W'(1) << (sh - SHIFT_W'(1));
        s = (s + rnd) >>> sh;
        if (relu && (s < 0))
            s = '0;
        if (s > SAT_HI)
            return SAT_HI[OUT_W-1:0];
        else if (s < SAT_LO)
            return SAT_LO[OUT_W-1:0];
        else
            return s[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        beat_hs    = 1'b0;
        last_hs    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.tile_valid) begin
                    capture    = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_valid_reg && bus.out_ready) begin
                    beat_hs = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        last_hs    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // On the capture edge the first element comes straight from c_in so (0,0) is valid next cycle.
    always_comb begin
        src_tile  = tile_reg;
        src_bias  = bias_reg;
        src_shift = shift_reg;
        src_relu  = relu_reg;
        idx_next  = idx_reg + IDX_W'(1);
        if (capture) begin
            src_tile  = bus.c_in;
            src_bias  = bus.bias;
            src_shift = bus.shift;
            src_relu  = bus.relu_en;
            idx_next  = '0;
        end
    end

`ifdef CONV_DRAIN_MAXPOOL_EN
    logic signed [OUT_W-1:0] win_q [4];
    logic signed [OUT_W-1:0] top_max, bot_max;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            localparam logic [1:0] DR = 2'(gi / 2);
            localparam logic [1:0] DC = 2'(gi % 2);
            logic [1:0] wr, wc;
            assign wr        = {idx_next[1], 1'b0} | DR;
            assign wc        = {idx_next[0], 1'b0} | DC;
            assign win_q[gi] = requant(src_tile[wr][wc], src_bias, src_shift, src_relu);
        end
    endgenerate

    always_comb begin
        top_max  = (win_q[0] > win_q[1]) ? win_q[0] : win_q[1];
        bot_max  = (win_q[2] > win_q[3]) ? win_q[2] : win_q[3];
        elem_q   = (top_max > bot_max) ? top_max : bot_max;
        row_next = {1'b0, idx_next[1]};
        col_next = {1'b0, idx_next[0]};
    end
`else
    always_comb begin
        row_next = idx_next[3:2];
        col_next = idx_next[1:0];
        elem_q   = requant(src_tile[row_next][col_next], src_bias, src_shift, src_relu);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_reg      <= '0;
            bias_reg      <= '0;
            shift_reg     <= '0;
            relu_reg      <= 1'b0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= last_hs;
            if (capture) begin
                tile_reg  <= bus.c_in;
                bias_reg  <= bus.bias;
                shift_reg <= bus.shift;
                relu_reg  <= bus.relu_en;
            end
            if (capture || (beat_hs && !last_hs)) begin
                idx_reg       <= idx_next;
                out_data_reg  <= elem_q;
                row_reg       <= row_next;
                col_reg       <= col_next;
                last_reg      <= (idx_next == LAST_IDX);
                out_valid_reg <= 1'b1;
            end else if (last_hs) begin
                out_valid_reg <= 1'b0;
                last_reg      <= 1'b0;
            end
        end
    end

    assign bus.tile_ready = (state_reg == IDLE);
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_row    = row_reg;
    assign bus.out_col    = col_reg;
    assign bus.out_last   = last_reg;
    assign bus.tile_done  = done_reg;
endmodule

// File: tb/tb_conv_tile_drain.sv
// Scoreboard bench for conv_tile_drain: a requant model queues expected beats at tile issue,
// a monitor pops and compares on every accepted beat.
module tb_conv_tile_drain;
    localparam int ACC_W = 16, BIAS_W = 16, SHIFT_W = 4, OUT_W = 8;
`ifdef CONV_DRAIN_MAXPOOL_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 16;
`endif

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } exp_t;

    logic clk;
    logic rst_n;

    conv_tile_drain_if #(.ACC_W(ACC_W), .BIAS_W(BIAS_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)) bus ();

    conv_tile_drain #(.ACC_W(ACC_W), .BIAS_W(BIAS_W), .SHIFT_W(SHIFT_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          tile_v[16];
    string       cur_test = "init";
    bit          last_hs_prev = 0;
    bit          stall_prev = 0;
    logic [12:0] held;

    function automatic int requant_m(int c, int b, int sh, bit relu);
        int s;
        s = c + b;
        if (sh > 0) s = s + (1 << (sh - 1));
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic push_tile(input int b, input int sh, input bit relu);
        int   q[16];
        exp_t e;
        for (int i = 0; i < 16; i++) q[i] = requant_m(tile_v[i], b, sh, relu);
`ifdef CONV_DRAIN_MAXPOOL_EN
        for (int p = 0; p < 4; p++) begin
            int m;
            m = -1000;
            for (int d = 0; d < 4; d++) begin
                int k;
                k = (2 * (p / 2) + d / 2) * 4 + 2 * (p % 2) + d % 2;
                if (q[k] > m) m = q[k];
            end
            e.data = m; e.row = p / 2; e.col = p % 2; e.last = (p == 3);
            exp_q.push_back(e);
        end
`else
        for (int i = 0; i < 16; i++) begin
            e.data = q[i]; e.row = i / 4; e.col = i % 4; e.last = (i == 15);
            exp_q.push_back(e);
        end
`endif
    endtask

    // Presents tile_v with the given parameters and holds tile_valid until the drain captures it.
    task automatic send_tile(input int b, input int sh, input bit relu);
        bit ok;
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                bus.c_in[r][c] = ACC_W'(tile_v[r * 4 + c]);
        bus.bias       = BIAS_W'(b);
        bus.shift      = SHIFT_W'(sh);
        bus.relu_en    = relu;
        bus.tile_valid = 1'b1;
        push_tile(b, sh, relu);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.tile_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.tile_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s capture: tile_ready never seen within 200 cycles", cur_test);
        end
    endtask

    // Drives out_ready (0: held high, 1: toggling 1,0,..., 2: random) until n tile_done pulses.
    task automatic run_ready(input int mode, input int n, output bit ok);
        ok = 0;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #1;
            case (mode)
                1:       bus.out_ready = (k % 2 == 0);
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (done_cnt >= n) begin
                ok = 1;
                break;
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        int   obs;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_hs_prev = 0;
                stall_prev   = 0;
            end else begin
                checks++;
                if (bus.tile_done !== last_hs_prev) begin
                    errors++;
                    $display("FAIL %s tile_done: got %b expected %b", cur_test, bus.tile_done, last_hs_prev);
                end
                if (bus.tile_done === 1'b1) done_cnt++;
                if (last_hs_prev) begin
                    checks++;
                    if (bus.tile_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL %s tile_ready_after_last: got %b expected 1", cur_test, bus.tile_ready);
                    end
                end
                if (stall_prev) begin
                    checks++;
                    if ({bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== held) begin
                        errors++;
                        $display("FAIL %s stall_hold: got %h expected %h", cur_test,
                                 {bus.out_data, bus.out_row, bus.out_col, bus.out_last}, held);
                    end
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    beat_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s beat: got unexpected beat data %0d, expected no beat", cur_test,
                                 $signed(bus.out_data));
                    end else begin
                        e   = exp_q.pop_front();
                        obs = int'($signed(bus.out_data));
                        if (obs !== e.data || int'(bus.out_row) !== e.row || int'(bus.out_col) !== e.col ||
                            bus.out_last !== e.last || bus.tile_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL %s beat %0d: got data=%0d row=%0d col=%0d last=%b rdy=%b, expected data=%0d row=%0d col=%0d last=%b rdy=0",
                                     cur_test, beat_cnt, obs, bus.out_row, bus.out_col, bus.out_last,
                                     bus.tile_ready, e.data, e.row, e.col, e.last);
                        end
                    end
                end
                last_hs_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1) && (bus.out_last === 1'b1);
                stall_prev   = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
                held         = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
            end
        end
    endtask

    task automatic start_test(input string name);
        cur_test = name;
        beat_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic finish_test(input bit ok, input int tiles);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done: got %0d tile_done pulses, expected %0d", cur_test, done_cnt, tiles);
        end
        checks++;
        if (exp_q.size() != 0 || beat_cnt != tiles * BEATS) begin
            errors++;
            $display("FAIL %s beats: got %0d beats with %0d left, expected %0d with 0 left",
                     cur_test, beat_cnt, exp_q.size(), tiles * BEATS);
        end
        exp_q.delete();
        $display("%s: %0d beats over %0d tile(s)", cur_test, beat_cnt, tiles);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.tile_ready !== 1'b1 || bus.out_data !== 8'sd0 ||
            bus.out_row !== 2'd0 || bus.out_col !== 2'd0 || bus.out_last !== 1'b0 || bus.tile_done !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got valid=%b ready=%b data=%0d row=%0d col=%0d last=%b done=%b, expected 0 1 0 0 0 0 0",
                     bus.out_valid, bus.tile_ready, bus.out_data, bus.out_row, bus.out_col, bus.out_last, bus.tile_done);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_uniform();
        bit ok;
        start_test("uniform");
        for (int i = 0; i < 16; i++) tile_v[i] = 100;
        send_tile(0, 0, 0);
        run_ready(0, 1, ok);
        finish_test(ok, 1);
    endtask

    task automatic test_requant();
        bit ok;
        start_test("requant");
        for (int i = 0; i < 16; i++) tile_v[i] = 64 * i;
        send_tile(-256, 2, 1);
        run_ready(0, 1, ok);
        finish_test(ok, 1);
    endtask

    task automatic test_stall();
        bit ok;
        start_test("stall");
        for (int i = 0; i < 16; i++) tile_v[i] = 100 + i;
        send_tile(3, 1, 0);
        run_ready(1, 1, ok);
        finish_test(ok, 1);
    endtask

    task automatic test_saturate();
        bit ok;
        start_test("saturate");
        for (int i = 0; i < 16; i++) tile_v[i] = 0;
        send_tile(-1000, 0, 0);
        send_tile(-1000, 0, 1);
        run_ready(0, 2, ok);
        finish_test(ok, 2);
    endtask

    task automatic test_mid_reset();
        bit ok;
        start_test("mid_reset");
        for (int i = 0; i < 16; i++) tile_v[i] = 7 * i;
        send_tile(0, 0, 0);
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (beat_cnt >= 5) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus.out_valid !== 1'b0 || bus.tile_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset drop: got valid=%b ready=%b reached5=%b, expected valid=0 ready=1 reached5=1",
                     bus.out_valid, bus.tile_ready, ok);
        end
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_test("after_reset");
        for (int i = 0; i < 16; i++) tile_v[i] = 3 * i + 1;
        send_tile(5, 0, 0);
        run_ready(0, 1, ok);
        finish_test(ok, 1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_test("back_to_back");
        for (int i = 0; i < 16; i++) tile_v[i] = 100;
        send_tile(0, 0, 0);
        for (int i = 0; i < 16; i++) tile_v[i] = 50 * i;
        send_tile(30, 3, 0);
        run_ready(0, 2, ok);
        finish_test(ok, 2);
    endtask

    task automatic test_random();
        bit ok;
        start_test("random");
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) tile_v[i] = int'($urandom_range(0, 65535));
            send_tile(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_ready(2, t + 1, ok);
        end
        finish_test(ok, 3);
    endtask

`ifdef CONV_DRAIN_MAXPOOL_EN
    task automatic test_maxpool();
        bit ok;
        start_test("maxpool");
        for (int i = 0; i < 16; i++) tile_v[i] = i;
        send_tile(0, 0, 0);
        run_ready(0, 1, ok);
        finish_test(ok, 1);
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        bus.tile_valid = 1'b0;
        bus.c_in       = '0;
        bus.bias       = '0;
        bus.shift      = '0;
        bus.relu_en    = 1'b0;
        bus.out_ready  = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_uniform();
        test_requant();
        test_stall();
        test_saturate();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef CONV_DRAIN_MAXPOOL_EN
        test_maxpool();
`endif
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
